// File: rtl/alu_arbiter_if.sv
// Request/response bundle for alu_arbiter: two operand request channels and one
// tagged result channel. master = requesters plus result consumer, slave = arbiter.
interface alu_arbiter_if #(
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned SEL_W = 4;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_A;
    logic [DATA_W-1:0] req0_B;
    logic [SEL_W-1:0]  req0_Sel;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_A;
    logic [DATA_W-1:0] req1_B;
    logic [SEL_W-1:0]  req1_Sel;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_Out;
    logic              rsp_CarryOut;
    logic              rsp_Zero;
    logic              rsp_Overflow;

    modport master (
        output req0_valid, req0_A, req0_B, req0_Sel,
        output req1_valid, req1_A, req1_B, req1_Sel,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_Out, rsp_CarryOut, rsp_Zero, rsp_Overflow
    );

    modport slave (
        input  req0_valid, req0_A, req0_B, req0_Sel,
        input  req1_valid, req1_A, req1_B, req1_Sel,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_Out, rsp_CarryOut, rsp_Zero, rsp_Overflow
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters, one transaction in flight.
// Optional per-requester completed-operation counters: define ALU_ARB_OPCOUNT_EN.
module alu_arbiter #(
    parameter int unsigned DATA_W = 8
`ifdef ALU_ARB_OPCOUNT_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     bus,
    output logic             busy
`ifdef ALU_ARB_OPCOUNT_EN
    ,
    output logic [CNT_W-1:0] op_cnt0,
    output logic [CNT_W-1:0] op_cnt1
`endif
);
    localparam int unsigned SEL_W = 4;
    localparam int unsigned MSB   = DATA_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [SEL_W-1:0]  op_sel;
    logic              op_id;

    logic              grant0_c;
    logic              grant1_c;
    logic [DATA_W:0]   sum_c;
    logic [DATA_W:0]   diff_c;
    logic [DATA_W-1:0] alu_out_c;
    logic              alu_carry_c;
    logic              alu_ovf_c;

    // Next state and round-robin grant; grants only exist while IDLE
    always_comb begin
        state_nxt = state;
        grant0_c  = 1'b0;
        grant1_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0_valid && (!bus.req1_valid || last_grant)) begin
                    grant0_c = 1'b1;
                end else if (bus.req1_valid) begin
                    grant1_c = 1'b1;
                end
                if (grant0_c || grant1_c) begin
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req0_ready = grant0_c;
    assign bus.req1_ready = grant1_c;

    // ALU on the latched operands; carry/overflow only meaningful for add/sub
    always_comb begin
        sum_c       = {1'b0, op_a} + {1'b0, op_b};
        diff_c      = {1'b0, op_a} - {1'b0, op_b};
        alu_out_c   = '0;
        alu_carry_c = 1'b0;
        alu_ovf_c   = 1'b0;
        case (op_sel)
            4'h0: begin
                alu_out_c   = sum_c[MSB:0];
                alu_carry_c = sum_c[DATA_W];
                alu_ovf_c   = (op_a[MSB] == op_b[MSB]) && (sum_c[MSB] != op_a[MSB]);
            end
            4'h1: begin
                alu_out_c   = diff_c[MSB:0];
                alu_carry_c = diff_c[DATA_W];
                alu_ovf_c   = (op_a[MSB] != op_b[MSB]) && (diff_c[MSB] != op_a[MSB]);
            end
            4'h2: alu_out_c = op_a & op_b;
            4'h3: alu_out_c = op_a | op_b;
            4'h4: alu_out_c = op_a ^ op_b;
            4'h5: alu_out_c = ~(op_a | op_b);
            4'h6: alu_out_c = {op_a[MSB-1:0], 1'b0};
            4'h7: alu_out_c = {1'b0, op_a[MSB:1]};
            4'h8: alu_out_c = ~(op_a & op_b);
            4'h9: alu_out_c = ~(op_a ^ op_b);
            4'hA: alu_out_c = DATA_W'(op_a <  op_b);
            4'hB: alu_out_c = DATA_W'(op_a == op_b);
            4'hC: alu_out_c = DATA_W'(op_a >  op_b);
            4'hD: alu_out_c = DATA_W'(op_a != op_b);
            4'hE: alu_out_c = DATA_W'(op_a >= op_b);
            4'hF: alu_out_c = DATA_W'(op_a <= op_b);
            default: alu_out_c = '0;
        endcase
    end

    // State register, operand capture and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            busy             <= 1'b0;
            last_grant       <= 1'b1;
            op_a             <= '0;
            op_b             <= '0;
            op_sel           <= '0;
            op_id            <= 1'b0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_id       <= 1'b0;
            bus.rsp_Out      <= '0;
            bus.rsp_CarryOut <= 1'b0;
            bus.rsp_Zero     <= 1'b0;
            bus.rsp_Overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            if (grant0_c || grant1_c) begin
                last_grant <= grant1_c;
                op_id      <= grant1_c;
                op_a       <= grant1_c ? bus.req1_A   : bus.req0_A;
                op_b       <= grant1_c ? bus.req1_B   : bus.req0_B;
                op_sel     <= grant1_c ? bus.req1_Sel : bus.req0_Sel;
            end
            if (state == EXEC) begin
                bus.rsp_valid    <= 1'b1;
                bus.rsp_id       <= op_id;
                bus.rsp_Out      <= alu_out_c;
                bus.rsp_CarryOut <= alu_carry_c;
                bus.rsp_Zero     <= (alu_out_c == '0);
                bus.rsp_Overflow <= alu_ovf_c;
            end else if ((state == RESP) && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_OPCOUNT_EN
    // Completed handshakes per requester, wrapping at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt0 <= '0;
            op_cnt1 <= '0;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            if (bus.rsp_id) begin
                op_cnt1 <= op_cnt1 + CNT_W'(1);
            end else begin
                op_cnt0 <= op_cnt0 + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_alu_arbiter;
    localparam int unsigned DATA_W = 8;
    localparam int LAT = 2;
`ifdef ALU_ARB_OPCOUNT_EN
    localparam int unsigned TB_CNT_W = 2;
    logic [TB_CNT_W-1:0] op_cnt0;
    logic [TB_CNT_W-1:0] op_cnt1;
    int mcnt[2];
`endif

    logic clk = 1'b0;
    logic rst;
    logic busy;

    alu_arbiter_if #(.DATA_W(DATA_W)) bus ();

    alu_arbiter #(
        .DATA_W(DATA_W)
`ifdef ALU_ARB_OPCOUNT_EN
        , .CNT_W(TB_CNT_W)
`endif
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
`ifdef ALU_ARB_OPCOUNT_EN
        , .op_cnt0(op_cnt0)
        , .op_cnt1(op_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference ALU from plain integer arithmetic
    function automatic void alu_ref(input int a, input int b, input int sel,
                                    output int out, output int c, output int o);
        int r, sa, sb, s;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        c = 0; o = 0; r = 0;
        case (sel)
            0:  begin r = a + b; c = (r > 255) ? 1 : 0; s = sa + sb; o = (s > 127 || s < -128) ? 1 : 0; end
            1:  begin r = a - b; c = (r < 0) ? 1 : 0;   s = sa - sb; o = (s > 127 || s < -128) ? 1 : 0; end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = ~(a | b);
            6:  r = a * 2;
            7:  r = a / 2;
            8:  r = ~(a & b);
            9:  r = ~(a ^ b);
            10: r = (a <  b) ? 1 : 0;
            11: r = (a == b) ? 1 : 0;
            12: r = (a >  b) ? 1 : 0;
            13: r = (a != b) ? 1 : 0;
            14: r = (a >= b) ? 1 : 0;
            default: r = (a <= b) ? 1 : 0;
        endcase
        out = r & 255;
    endfunction

    // Round-robin choice: -1 none, otherwise requester index
    function automatic int pick(input logic v0, input logic v1, input int last);
        if (v0 && v1) return (last == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Transaction-level model
    bit model_on = 1'b0;
    bit inflight = 1'b0;
    bit exp_valid = 1'b0;
    int age = 0;
    int last_g = 1;
    int grant_m, grant_c;
    int p_id, p_out, p_c, p_o;
    int e_id = 0, e_out = 0, e_c = 0, e_z = 0, e_o = 0;

    always @(posedge clk) begin
        if (rst) begin
            model_on = 1'b1;
            inflight = 1'b0;
            exp_valid = 1'b0;
            last_g = 1;
            e_id = 0; e_out = 0; e_c = 0; e_z = 0; e_o = 0;
`ifdef ALU_ARB_OPCOUNT_EN
            mcnt[0] = 0; mcnt[1] = 0;
`endif
        end else if (inflight) begin
            if (exp_valid) begin
                if (bus.rsp_ready) begin
`ifdef ALU_ARB_OPCOUNT_EN
                    mcnt[e_id] = (mcnt[e_id] + 1) % (1 << TB_CNT_W);
`endif
                    inflight = 1'b0;
                    exp_valid = 1'b0;
                end
            end else begin
                age++;
                if (age >= LAT) begin
                    exp_valid = 1'b1;
                    e_id = p_id; e_out = p_out; e_c = p_c; e_o = p_o;
                    e_z = (p_out == 0) ? 1 : 0;
                end
            end
        end else begin
            grant_m = pick(bus.req0_valid, bus.req1_valid, last_g);
            if (grant_m >= 0) begin
                inflight = 1'b1;
                age = 1;
                last_g = grant_m;
                p_id = grant_m;
                if (grant_m == 0)
                    alu_ref(int'(bus.req0_A), int'(bus.req0_B), int'(bus.req0_Sel), p_out, p_c, p_o);
                else
                    alu_ref(int'(bus.req1_A), int'(bus.req1_B), int'(bus.req1_Sel), p_out, p_c, p_o);
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_on) begin
            grant_c = inflight ? -1 : pick(bus.req0_valid, bus.req1_valid, last_g);
            chk("m_req0_ready", int'(bus.req0_ready), (grant_c == 0) ? 1 : 0);
            chk("m_req1_ready", int'(bus.req1_ready), (grant_c == 1) ? 1 : 0);
            chk("m_busy", int'(busy), inflight ? 1 : 0);
            chk("m_rsp_valid", int'(bus.rsp_valid), exp_valid ? 1 : 0);
            chk("m_rsp_id", int'(bus.rsp_id), e_id);
            chk("m_rsp_Out", int'(bus.rsp_Out), e_out);
            chk("m_rsp_CarryOut", int'(bus.rsp_CarryOut), e_c);
            chk("m_rsp_Zero", int'(bus.rsp_Zero), e_z);
            chk("m_rsp_Overflow", int'(bus.rsp_Overflow), e_o);
`ifdef ALU_ARB_OPCOUNT_EN
            chk("m_op_cnt0", int'(op_cnt0), mcnt[0]);
            chk("m_op_cnt1", int'(op_cnt1), mcnt[1]);
`endif
        end
    end

    task automatic clear_reqs();
        bus.req0_valid = 1'b0; bus.req0_A = '0; bus.req0_B = '0; bus.req0_Sel = '0;
        bus.req1_valid = 1'b0; bus.req1_A = '0; bus.req1_B = '0; bus.req1_Sel = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Present one request for a single cycle; returns one cycle after the accept
    task automatic issue(input int id, input int a, input int b, input int sel);
        @(posedge clk); #1;
        if (id == 0) begin
            bus.req0_valid = 1'b1; bus.req0_A = 8'(a); bus.req0_B = 8'(b); bus.req0_Sel = 4'(sel);
        end else begin
            bus.req1_valid = 1'b1; bus.req1_A = 8'(a); bus.req1_B = 8'(b); bus.req1_Sel = 4'(sel);
        end
        @(negedge clk);
        chk("accept", int'((id == 0) ? bus.req0_ready : bus.req1_ready), 1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Response must be absent one cycle after accept and present the cycle after
    task automatic expect_rsp(input int id, input int out, input int c, input int z, input int o);
        @(negedge clk);
        chk("lat_early_valid", int'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("lat_valid", int'(bus.rsp_valid), 1);
        chk("lit_id", int'(bus.rsp_id), id);
        chk("lit_Out", int'(bus.rsp_Out), out);
        chk("lit_CarryOut", int'(bus.rsp_CarryOut), c);
        chk("lit_Zero", int'(bus.rsp_Zero), z);
        chk("lit_Overflow", int'(bus.rsp_Overflow), o);
    endtask

    initial begin
        int gq[$];
        int tq[$];
        int rq[$];
        int cyc;
        int exp_ids[4];

        rst = 1'b1;
        clear_reqs();
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_Out", int'(bus.rsp_Out), 0);
        chk("rst_rsp_id", int'(bus.rsp_id), 0);

        // Single add with signed overflow
        bus.rsp_ready = 1'b1;
        issue(0, 8'h7F, 8'h01, 0);
        expect_rsp(0, 8'h80, 0, 0, 1);
        @(negedge clk);
        chk("resp_one_cycle", int'(bus.rsp_valid), 0);
        chk("idle_after_resp", int'(busy), 0);

        // Subtract with borrow
        issue(1, 8'h03, 8'h05, 1);
        expect_rsp(1, 8'hFE, 1, 0, 0);

        // Contention from reset: alternate grants, 3 cycles apart
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_A = 8'hF0; bus.req0_B = 8'h3C; bus.req0_Sel = 4'h2;
        bus.req1_valid = 1'b1; bus.req1_A = 8'h0F; bus.req1_B = 8'h3C; bus.req1_Sel = 4'h2;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                gq.push_back(bus.req1_ready ? 1 : 0);
                tq.push_back(i);
            end
            if (bus.rsp_valid) rq.push_back(int'(bus.rsp_id));
        end
        @(posedge clk); #1;
        clear_reqs();
        exp_ids = '{0, 1, 0, 1};
        chk("cont_grant_count", gq.size(), 4);
        chk("cont_rsp_count", rq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) chk("cont_grant_id", gq[i], exp_ids[i]);
            if (i < rq.size()) chk("cont_rsp_id", rq[i], exp_ids[i]);
            if (i > 0 && i < tq.size()) chk("cont_interval", tq[i] - tq[i-1], 3);
        end
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: response held stable, no grants while busy
        bus.rsp_ready = 1'b0;
        issue(0, 8'hAA, 8'hAA, 4);
        bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready1_exec", int'(bus.req1_ready), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(bus.rsp_valid), 1);
            chk("bp_Out", int'(bus.rsp_Out), 0);
            chk("bp_Zero", int'(bus.rsp_Zero), 1);
            chk("bp_ready0", int'(bus.req0_ready), 0);
            chk("bp_ready1", int'(bus.req1_ready), 0);
        end
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", int'(bus.rsp_valid), 1);
        @(negedge clk);
        chk("bp_after_valid", int'(bus.rsp_valid), 0);
        chk("bp_after_busy", int'(busy), 0);

        // Reset during EXEC drops the transaction and restores requester-0 priority
        issue(0, 8'h12, 8'h34, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_valid", int'(bus.rsp_valid), 0);
            chk("rst_mid_busy", int'(busy), 0);
            chk("rst_mid_Out", int'(bus.rsp_Out), 0);
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_mid_grant0", int'(bus.req0_ready), 1);
        chk("rst_mid_grant1", int'(bus.req1_ready), 0);
        @(posedge clk); #1;
        clear_reqs();
        repeat (4) @(posedge clk);

        // Randomized traffic, checked by the model every cycle
        cyc = 0;
        while (cyc < 3000) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 199) == 0);
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req0_A     = 8'($urandom);
            bus.req0_B     = 8'($urandom_range(0, 3) == 0 ? bus.req0_A : 8'($urandom));
            bus.req0_Sel   = 4'($urandom);
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req1_A     = 8'($urandom);
            bus.req1_B     = 8'($urandom);
            bus.req1_Sel   = 4'($urandom);
            bus.rsp_ready  = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_reqs();
        bus.rsp_ready = 1'b1;
        repeat (6) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 8-bit ALU datapath between two requesters (e.g. two sequencer ports).
- Each requester issues operand/opcode transactions over valid/ready.
- Round-robin grant; operands captured, executed in the internal ALU, result plus flags returned over a single valid/ready response channel tagged with the requester ID.
- One transaction in flight at a time.

Parameters:
- DATA_W, 8, operand/result width; only 8 is supported (ALU is 8-bit).
- CNT_W, 16, width of the completed-operation counters (optional feature only).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 transaction valid
- req0_ready  output  1  requester 0 accepted this cycle
- req0_A  input  8  requester 0 operand A
- req0_B  input  8  requester 0 operand B
- req0_Sel  input  4  requester 0 ALU opcode
- req1_valid  input  1  requester 1 transaction valid
- req1_ready  output  1  requester 1 accepted this cycle
- req1_A  input  8  requester 1 operand A
- req1_B  input  8  requester 1 operand B
- req1_Sel  input  4  requester 1 ALU opcode
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  1  requester that issued the result
- rsp_Out  output  8  ALU result
- rsp_CarryOut  output  1  carry/borrow
- rsp_Zero  output  1  result == 0
- rsp_Overflow  output  1  signed overflow
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - All rsp_* outputs = 0.
  - req*_ready = 0.
  - busy = 0.
  - last_grant = 1, so requester 0 wins the first contention.
- FSM states:
  - IDLE:
    - req*_ready are combinational from state and valids: high only in IDLE and only for the granted requester.
    - If any req*_valid is high: grant, latch A/B/Sel/id into operand registers, go to EXEC.
  - EXEC:
    - Apply latched operands to the ALU.
    - Register Out/CarryOut/Zero/Overflow into rsp_*.
    - Set rsp_valid = 1 and go to RESP.
  - RESP:
    - Hold all rsp_* stable while rsp_valid && !rsp_ready.
    - On rsp_ready: clear rsp_valid and return to IDLE.
    - No new request is accepted in the same cycle as the rsp_ready handshake.
- Grant rule:
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - last_grant updates on every accept.
- Latency: accept in cycle N → rsp_valid high in cycle N+2. Minimum issue interval is 3 cycles.
- Opcode set (executed in EXEC):
  - 0000 A+B: 9-bit sum, CarryOut = bit 8.
  - 0001 A−B: 9-bit difference, CarryOut = bit 8 (borrow).
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 NOR.
  - 0110 A<<1.
  - 0111 A>>1 (logical).
  - 1000 NAND.
  - 1001 XNOR.
  - 1010–1111 unsigned compares <, ==, >, !=, >=, <=; result 8'h01 if true, else 8'h00.
- Flag rules:
  - CarryOut and Overflow are 0 for every opcode except 0000/0001.
  - Overflow for add: A7==B7 && Out7!=A7.
  - Overflow for sub: A7!=B7 && Out7!=A7.
  - Zero = (Out == 0) for all opcodes.
- Boundary conditions:
  - Operand inputs are ignored outside IDLE; changes to req* while busy have no effect on the in-flight result.
  - A requester that deasserts valid before being granted is simply not granted; no error.
  - rsp_ready held high continuously: RESP lasts exactly 1 cycle.
  - rst asserted in any state: next cycle is IDLE with reset values; an in-flight transaction is dropped with no response.

Optional Feature:
- Macro: ALU_ARB_OPCOUNT_EN.
- Defined:
  - Adds outputs op_cnt0 and op_cnt1, each CNT_W bits wide.
  - Each counter increments by 1 on every completed response handshake (rsp_valid && rsp_ready) for the matching rsp_id.
  - Counters wrap from all-ones to 0 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single add: req0 A=8'h7F, B=8'h01, Sel=0000, rsp_ready=1 → 2 cycles later rsp_valid=1, id=0, Out=8'h80, CarryOut=0, Overflow=1, Zero=0.
- Sub borrow: req1 A=8'h03, B=8'h05, Sel=0001 → Out=8'hFE, CarryOut=1, Overflow=0, id=1.
- Contention: both valid continuously with AND ops from reset, rsp_ready=1 → grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; each accept 3 cycles apart.
- Backpressure: req0 XOR A=B=8'hAA, rsp_ready=0 for 5 cycles → rsp_valid held, Out=8'h00, Zero=1 stable, req*_ready=0 throughout; release → IDLE next cycle.
- Reset mid-op: accept req0 then assert rst during EXEC → rsp_valid never rises; all outputs 0 next cycle; next contention grants requester 0.
- With ALU_ARB_OPCOUNT_EN: 3 req0 ops + 2 req1 ops completed → op_cnt0=3, op_cnt1=2; CNT_W=2 with 5 req0 ops → op_cnt0=1.
